// File: rtl/mii_tx_pkg.sv
// Shared types and constants for the MII transmit framer: state encoding,
// frame timing constants and reflected CRC-32 parameters.
package mii_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_SFD,
    ST_DATA,
    ST_PAD,
    ST_FCS,
    ST_ABORT,
    ST_IFG
  } tx_state_e;

  localparam int PREAMBLE_NIBBLES = 15;
  localparam int IFG_NIBBLES      = 24;
  localparam int MIN_FRAME_BYTES  = 60;
  localparam int FCS_NIBBLES      = 8;

  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB8_8320;
  // Register value after running the CRC over a frame plus its own FCS.
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB_20E3;

endpackage

// File: rtl/mii_tx_framer_if.sv
// MAC-side byte stream into the framer: valid/ready handshake with
// last and error qualifiers.
interface mii_tx_framer_if;
  logic [7:0] tx_mac_data;
  logic       tx_mac_valid;
  logic       tx_mac_last;
  logic       tx_mac_err;
  logic       tx_mac_ready;

  modport master (
    output tx_mac_data, tx_mac_valid, tx_mac_last, tx_mac_err,
    input  tx_mac_ready
  );

  modport slave (
    input  tx_mac_data, tx_mac_valid, tx_mac_last, tx_mac_err,
    output tx_mac_ready
  );
endinterface

// File: rtl/mii_tx_framer_crc32_nibble.sv
// Combinational reflected CRC-32 update for one nibble, LSB of the nibble
// shifted in first (matches MII nibble order).
module crc32_nibble
  import mii_tx_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [3:0]  nibble,
  output logic [31:0] crc_next
);

  always_comb begin
    crc_next = crc;
    for (int i = 0; i < 4; i++)
      crc_next = (crc_next[0] ^ nibble[i]) ? ((crc_next >> 1) ^ CRC_POLY_REFL)
                                           : (crc_next >> 1);
  end

endmodule

// File: rtl/mii_tx_framer.sv
// MII transmit framer: preamble/SFD, byte-to-nibble data, optional padding
// (build with MII_TX_PAD_EN), FCS, underrun abort and inter-frame gap.
module mii_tx_framer
  import mii_tx_pkg::*;
(
  input  logic            phy_tx_clk,
  input  logic            reset,
  mii_tx_framer_if.slave  mac,
  output logic [3:0]      phy_txd,
  output logic            phy_tx_en,
  output logic            phy_tx_err
);

  tx_state_e   state;
  logic [4:0]  nib_cnt;
  logic [10:0] byte_cnt;
  logic [10:0] byte_cnt_inc;
  logic [31:0] crc;
  logic [31:0] crc_upd;
  logic [3:0]  crc_din;
  logic [7:0]  hold_data;
  logic        hold_err;
  logic        hi_phase;
  logic        last_seen;
  logic        ready;
  logic        accept;
  logic        pad_needed;

  assign mac.tx_mac_ready = ready;
  assign accept           = mac.tx_mac_valid & ready;
  assign byte_cnt_inc     = (byte_cnt == 11'h7FF) ? byte_cnt : byte_cnt + 11'd1;

`ifdef MII_TX_PAD_EN
  assign pad_needed = (byte_cnt < 11'(MIN_FRAME_BYTES));
`else
  assign pad_needed = 1'b0;
`endif

  // Nibble entering the CRC on this edge: the held high nibble, the low
  // nibble of a byte being accepted, or zero while padding.
  always_comb begin
    crc_din = 4'h0;
    if (state == ST_DATA && !hi_phase) crc_din = hold_data[7:4];
    else if (accept)                   crc_din = mac.tx_mac_data[3:0];
  end

  crc32_nibble u_crc (
    .crc      (crc),
    .nibble   (crc_din),
    .crc_next (crc_upd)
  );

  always_ff @(posedge phy_tx_clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      nib_cnt    <= '0;
      byte_cnt   <= '0;
      crc        <= CRC_INIT;
      hold_data  <= '0;
      hold_err   <= 1'b0;
      hi_phase   <= 1'b0;
      last_seen  <= 1'b0;
      ready      <= 1'b0;
      phy_txd    <= 4'h0;
      phy_tx_en  <= 1'b0;
      phy_tx_err <= 1'b0;
    end else begin
      if (accept) begin
        byte_cnt  <= byte_cnt_inc;
        hold_data <= mac.tx_mac_data;
        hold_err  <= mac.tx_mac_err;
        last_seen <= mac.tx_mac_last;
      end
      case (state)
        ST_IDLE, ST_IFG: begin
          phy_txd    <= 4'h0;
          phy_tx_en  <= 1'b0;
          phy_tx_err <= 1'b0;
          ready      <= 1'b0;
          if (state == ST_IDLE) begin
            byte_cnt <= '0;
            crc      <= CRC_INIT;
          end
          if (state == ST_IFG && nib_cnt != 5'(IFG_NIBBLES - 1)) begin
            nib_cnt <= nib_cnt + 5'd1;
          end else if (mac.tx_mac_valid) begin
            state     <= ST_PREAMBLE;
            nib_cnt   <= '0;
            byte_cnt  <= '0;
            crc       <= CRC_INIT;
            last_seen <= 1'b0;
            phy_txd   <= 4'h5;
            phy_tx_en <= 1'b1;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_PREAMBLE: begin
          if (nib_cnt == 5'(PREAMBLE_NIBBLES - 1)) begin
            state   <= ST_SFD;
            phy_txd <= 4'hD;
            ready   <= 1'b1;
          end else begin
            nib_cnt <= nib_cnt + 5'd1;
          end
        end
        ST_SFD, ST_DATA: begin
          if (state == ST_DATA && !hi_phase) begin
            phy_txd    <= hold_data[7:4];
            phy_tx_err <= hold_err;
            crc        <= crc_upd;
            hi_phase   <= 1'b1;
            ready      <= !last_seen;
          end else if (state == ST_DATA && last_seen) begin
            phy_tx_err <= 1'b0;
            if (pad_needed) begin
              state    <= ST_PAD;
              hi_phase <= 1'b0;
              phy_txd  <= 4'h0;
              crc      <= crc_upd;
            end else begin
              state   <= ST_FCS;
              nib_cnt <= '0;
              phy_txd <= ~crc[3:0];
              crc     <= crc >> 4;
            end
          end else if (mac.tx_mac_valid) begin
            state      <= ST_DATA;
            hi_phase   <= 1'b0;
            phy_txd    <= mac.tx_mac_data[3:0];
            phy_tx_err <= mac.tx_mac_err;
            crc        <= crc_upd;
            ready      <= 1'b0;
          end else begin
            // Underrun: MAC had no byte when one was due.
            state      <= ST_ABORT;
            nib_cnt    <= '0;
            phy_txd    <= 4'h0;
            phy_tx_err <= 1'b1;
            ready      <= 1'b0;
          end
        end
        ST_PAD: begin
          if (!hi_phase) begin
            hi_phase <= 1'b1;
            crc      <= crc_upd;
            byte_cnt <= byte_cnt_inc;
          end else if (byte_cnt >= 11'(MIN_FRAME_BYTES)) begin
            state   <= ST_FCS;
            nib_cnt <= '0;
            phy_txd <= ~crc[3:0];
            crc     <= crc >> 4;
          end else begin
            hi_phase <= 1'b0;
            crc      <= crc_upd;
          end
        end
        ST_FCS: begin
          if (nib_cnt == 5'(FCS_NIBBLES - 1)) begin
            state     <= ST_IFG;
            nib_cnt   <= '0;
            phy_txd   <= 4'h0;
            phy_tx_en <= 1'b0;
          end else begin
            nib_cnt <= nib_cnt + 5'd1;
            phy_txd <= ~crc[3:0];
            crc     <= crc >> 4;
          end
        end
        ST_ABORT: begin
          if (nib_cnt == 5'd1) begin
            state      <= ST_IFG;
            nib_cnt    <= '0;
            phy_tx_en  <= 1'b0;
            phy_tx_err <= 1'b0;
          end else begin
            nib_cnt <= nib_cnt + 5'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mii_tx_framer.md
MII_TX_FRAMER -- requirements
Module: mii_tx_framer

Interface
REQ-001 The block SHALL have one clock and reset, which is asynchronous and active-low.
REQ-002 The ports SHALL be, clock and reset first, each given as name, direction, width, meaning:
- phy_tx_clk  in  1  MII nibble clock (25 MHz / 2.5 MHz), sole clock.
- reset  in  1  asynchronous active-low reset.
- tx_mac_data  in  8  frame byte (DA first, no preamble/FCS).
- tx_mac_valid  in  1  byte valid.
- tx_mac_last  in  1  final byte of frame, qualified by valid.
- tx_mac_err  in  1  corrupt-byte flag, qualified by valid.
- tx_mac_ready  out  1  byte accepted on this edge when valid=1.
- phy_txd  out  4  MII transmit nibble.
- phy_tx_en  out  1  MII transmit enable.
- phy_tx_err  out  1  MII transmit error.

Function
REQ-003 States SHALL be IDLE, PREAMBLE, SFD, DATA, PAD, FCS, ABORT and IFG; all outputs SHALL be registered.
REQ-004 IDLE: when tx_mac_valid=1, the block SHALL enter PREAMBLE on the next edge; phy_tx_en=0 and phy_txd=0 in IDLE.
REQ-005 PREAMBLE SHALL drive 15 nibbles of 0x5 with phy_tx_en=1; SFD SHALL then drive one nibble 0xD.
REQ-006 Handshake: tx_mac_ready SHALL be high in the SFD cycle and in every DATA cycle carrying a high nibble, except after the last byte has been accepted; it SHALL be low otherwise.
REQ-007 A byte accepted (valid&ready) SHALL appear on phy_txd on the next cycle (low nibble), and on the cycle after that (high nibble).
REQ-008 tx_mac_err on an accepted byte SHALL assert phy_tx_err for both nibbles of that byte; the frame SHALL continue and FCS SHALL still be sent.
REQ-009 Underrun: tx_mac_valid=0 while tx_mac_ready=1 in DATA/SFD SHALL enter ABORT.
- ABORT drives 2 nibbles with phy_tx_en=1, phy_tx_err=1, phy_txd=0, then IFG.
- ABORT sends no FCS.
REQ-010 After the last byte, the block SHALL go to PAD (per REQ-016) or FCS.
REQ-011 FCS SHALL drive 8 nibbles of the complemented CRC-32, least significant nibble first. The CRC is reflected polynomial 0x04C11DB7, initialised to 0xFFFFFFFF, and computed over DA through the last data/pad byte.
REQ-012 IFG SHALL hold phy_tx_en=0 for exactly 24 cycles (96 bit times) before returning to IDLE; tx_mac_ready=0 throughout, and valid pending at IFG end starts PREAMBLE on the next edge.
REQ-013 The byte counter SHALL be 11 bits, saturating at 2047, and SHALL be cleared in IDLE.
REQ-014 Oversize frames SHALL NOT be truncated.

Reset
REQ-015 While reset=0, the block SHALL force state IDLE, phy_txd=0, phy_tx_en=0, phy_tx_err=0, tx_mac_ready=0, CRC to 0xFFFFFFFF and counters to 0, immediately and including mid-frame; it SHALL resume in IDLE on the first edge after release.

Configuration
REQ-016 With MII_TX_PAD_EN defined, frames under 60 bytes SHALL be padded with 0x00 bytes in PAD up to 60 bytes before FCS; without the macro, PAD SHALL be absent and FCS SHALL immediately follow the last byte for any length.

Structure
REQ-017 The shared package mii_tx_pkg SHALL hold:
- state enum;
- PREAMBLE_NIBBLES=15, IFG_NIBBLES=24, MIN_FRAME_BYTES=60, FCS_NIBBLES=8;
- CRC_INIT=0xFFFFFFFF, CRC_POLY_REFL=0xEDB88320, CRC_RESIDUE.
REQ-018 One sub-module crc32_nibble SHALL be provided (combinational 4-bit CRC update, instanced once).

Verification
REQ-019 Bytes "123456789" (ASCII) with MII_TX_PAD_EN off SHALL produce 15×0x5, 0xD, 18 data nibbles, then FCS nibbles 6,2,9,3,4,F,B,C (CRC 0xCBF43926).
REQ-020 A 1-byte frame 0xAB with MII_TX_PAD_EN on SHALL produce nibbles B,A, then 118 nibbles of 0, then 8 FCS nibbles; phy_tx_en SHALL be high for 144 cycles.
REQ-021 Back-to-back 64-byte frames with valid held high SHALL give exactly 24 cycles of phy_tx_en=0 between frames.
REQ-022 Dropping tx_mac_valid at byte 20 SHALL give 2 cycles of phy_tx_err=1, no FCS, then IFG.
REQ-023 Byte 5 with tx_mac_err=1 SHALL set phy_tx_err=1 on exactly its 2 nibbles, with the FCS still correct over the data.
REQ-024 Asserting reset during FCS nibble 3 SHALL force phy_tx_en=0 immediately; the next frame after release SHALL start with a full 15-nibble preamble.
